// File: rtl/bdm_target_pkg.sv
// Shared BDM target definitions: FSM states, default BDC timing, helpers.
// Optional SYNC response is enabled by defining BDM_TGT_SYNC_RESP_EN.
`timescale 1ns/1ps
package bdm_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HOLD,
    ST_WAIT_HIGH,
    ST_SYNC_WAIT_HIGH,
    ST_SYNC_DELAY,
    ST_SYNC_DRIVE
  } bdm_state_e;

  localparam int unsigned BDC_DIV_DEF        = 8;
  localparam int unsigned MIN_LOW_DEF        = 2;
  localparam int unsigned SAMPLE_BDC_DEF     = 10;
  localparam int unsigned HOLD_BDC_DEF       = 13;
  localparam int unsigned SYNC_MIN_BDC_DEF   = 128;
  localparam int unsigned SYNC_DELAY_BDC_DEF = 16;
  localparam int unsigned SYNC_PULSE_BDC_DEF = 128;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bdm_target_edge_sync.sv
// bkgd input synchronizer (2 FF) with rise/fall pulses on the synced level.
// Idles high so a reset release on an idle line produces no edge.
`timescale 1ns/1ps
module bdm_target_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic lvl_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      lvl_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      lvl_q  <= meta_q;
      prev_q <= lvl_q;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = lvl_q & ~prev_q;
  assign fall_o = ~lvl_q & prev_q;

endmodule

// File: rtl/bdm_target.sv
// Target-side single-wire BDM responder: rx/tx bit slots and SYNC detect.
// Define BDM_TGT_SYNC_RESP_EN to answer SYNC with a timed low pulse.
`timescale 1ns/1ps
module bdm_target
  import bdm_target_pkg::*;
#(
  parameter int unsigned BDC_DIV        = BDC_DIV_DEF,
  parameter int unsigned MIN_LOW        = MIN_LOW_DEF,
  parameter int unsigned SAMPLE_BDC     = SAMPLE_BDC_DEF,
  parameter int unsigned HOLD_BDC       = HOLD_BDC_DEF,
  parameter int unsigned SYNC_MIN_BDC   = SYNC_MIN_BDC_DEF,
  parameter int unsigned SYNC_DELAY_BDC = SYNC_DELAY_BDC_DEF,
  parameter int unsigned SYNC_PULSE_BDC = SYNC_PULSE_BDC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bkgd_in,
  output logic       bkgd_out,
  output logic       bkgd_is_high_z,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       sync_seen
);

  localparam logic [15:0] T_MIN    = 16'(MIN_LOW);
  localparam logic [15:0] T_SAMPLE = 16'(SAMPLE_BDC * BDC_DIV);
  localparam logic [15:0] T_HOLD   = 16'(HOLD_BDC * BDC_DIV);
  localparam logic [15:0] T_SYNC   = 16'(SYNC_MIN_BDC * BDC_DIV);
  localparam logic [15:0] T_DELAY  = 16'(SYNC_DELAY_BDC * BDC_DIV);
  localparam logic [15:0] T_PULSE  = 16'(SYNC_PULSE_BDC * BDC_DIV);

  logic lvl;
  logic rise;
  logic fall;

  bdm_target_edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bkgd_in),
    .lvl_o  (lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  bdm_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_done_q, tx_done_d;
  logic        sync_seen_q, sync_seen_d;
  logic        slot_tx_q, slot_tx_d;
  logic        drive_q, drive_d;
  logic        in_slot;

  always_comb begin
    state_d     = state_q;
    cnt_d       = sat_inc(cnt_q);
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_sh_d     = tx_sh_q;
    tx_busy_d   = tx_busy_q;
    tx_done_d   = 1'b0;
    sync_seen_d = 1'b0;
    slot_tx_d   = slot_tx_q;
    drive_d     = drive_q;
    in_slot     = (state_q == ST_LOW)
               || (state_q == ST_HOLD)
               || (state_q == ST_WAIT_HIGH);

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d   = ST_LOW;
          cnt_d     = 16'd1;
          slot_tx_d = tx_busy_q;
        end
      end
      ST_LOW: begin
        if (rise && (cnt_q <= T_MIN)) begin
          state_d = ST_IDLE;
        end else if (cnt_q == T_SAMPLE) begin
          if (slot_tx_q) begin
            state_d = ST_HOLD;
            drive_d = ~tx_sh_q[7];
          end else begin
            state_d = ST_WAIT_HIGH;
            // a load mid-slot already discarded this byte
            if (!tx_busy_q) begin
              rx_sh_d   = {rx_sh_q[5:0], lvl};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_data_d  = {rx_sh_q, lvl};
                rx_valid_d = 1'b1;
              end
            end
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == T_HOLD) begin
          state_d   = ST_WAIT_HIGH;
          drive_d   = 1'b0;
          tx_sh_d   = {tx_sh_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            tx_done_d = 1'b1;
            tx_busy_d = 1'b0;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (lvl) state_d = ST_IDLE;
      end
      ST_SYNC_WAIT_HIGH: begin
        if (lvl) begin
`ifdef BDM_TGT_SYNC_RESP_EN
          state_d = ST_SYNC_DELAY;
          cnt_d   = 16'd1;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_SYNC_DELAY: begin
        if (cnt_q == T_DELAY) begin
          state_d = ST_SYNC_DRIVE;
          drive_d = 1'b1;
          cnt_d   = 16'd1;
        end
      end
      ST_SYNC_DRIVE: begin
        if (cnt_q == T_PULSE) begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_load && !tx_busy_q) begin
      tx_sh_d   = tx_data;
      tx_busy_d = 1'b1;
      bit_cnt_d = '0;
    end

    // SYNC wins over everything in the slot, including a fresh load
    if (in_slot && !lvl && (cnt_q == T_SYNC)) begin
      state_d     = ST_SYNC_WAIT_HIGH;
      drive_d     = 1'b0;
      bit_cnt_d   = '0;
      tx_busy_d   = 1'b0;
      tx_done_d   = 1'b0;
      rx_valid_d  = 1'b0;
      sync_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_sh_q     <= '0;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      sync_seen_q <= 1'b0;
      slot_tx_q   <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_sh_q     <= tx_sh_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
      sync_seen_q <= sync_seen_d;
      slot_tx_q   <= slot_tx_d;
      drive_q     <= drive_d;
    end
  end

  assign bkgd_out       = 1'b0;
  assign bkgd_is_high_z = ~drive_q;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign tx_busy        = tx_busy_q;
  assign tx_done        = tx_done_q;
  assign sync_seen      = sync_seen_q;

endmodule

// File: tb/tb_bdm_target.sv
// Directed/random bench for bdm_target with a wired-AND bkgd line model.
// Host slot timing is driven from the bench; BDC_DIV=4.
`timescale 1ns/1ps
module tb_bdm_target;

  localparam int DIV = 4;
`ifdef BDM_TGT_SYNC_RESP_EN
  localparam bit RESP = 1'b1;
`else
  localparam bit RESP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_lvl = 1'b1;
  logic       pin;
  logic       bkgd_out;
  logic       bkgd_is_high_z;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_busy;
  logic       tx_done;
  logic       sync_seen;

  assign pin = host_lvl & (bkgd_is_high_z | bkgd_out);

  bdm_target #(.BDC_DIV(DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bkgd_in        (pin),
    .bkgd_out       (bkgd_out),
    .bkgd_is_high_z (bkgd_is_high_z),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_load        (tx_load),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .sync_seen      (sync_seen)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          n_done = 0;
  int          n_sync = 0;
  int unsigned sync_cyc = 0;

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (tx_done) n_done++;
    if (sync_seen) begin
      n_sync++;
      sync_cyc = cyc;
    end
  end

  int cmp = 0;
  int mis = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one host slot: low for lo clks, 70 clks total;
  // optionally checks the target's drive during a read slot
  task automatic slot(input int lo, input bit chk, input bit exp_hz);
    @(negedge clk);
    host_lvl = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == lo) host_lvl = 1'b1;
      if (chk && k == 46) check("tx_drive", 32'(bkgd_is_high_z), 32'(exp_hz));
      if (chk && k == 58) check("tx_release", 32'(bkgd_is_high_z), 1);
    end
  endtask

  task automatic wr_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) slot(b[7-i] ? 16 : 52, 1'b0, 1'b0);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    int n0;
    n0 = got_q.size();
    wr_bits(b, 8);
    exp_q.push_back(b);
    check("rx_count", 32'(got_q.size() - n0), 1);
    if (got_q.size() > 0) check("rx_data", 32'(got_q[$]), 32'(b));
  endtask

  task automatic rd_bits(input logic [7:0] b, input int first, input int n);
    for (int i = first; i < first + n; i++) slot(16, 1'b1, b[7-i]);
  endtask

  task automatic load(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    check("tx_busy_set", 32'(tx_busy), 1);
  endtask

  task automatic glitch(input int n);
    @(negedge clk);
    host_lvl = 1'b0;
    repeat (n) @(negedge clk);
    host_lvl = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic do_sync();
    int unsigned c0;
    int s0;
    int d;
    @(negedge clk);
    host_lvl = 1'b0;
    c0 = cyc;
    s0 = n_sync;
    repeat (600) @(negedge clk);
    host_lvl = 1'b1;
    d = int'(sync_cyc - c0);
    check("sync_once", 32'(n_sync - s0), 1);
    check("sync_time", 32'(d >= 512 && d <= 518), 1);
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (k == 60)  check("sync_pre", 32'(bkgd_is_high_z), 1);
      if (k == 75)  check("sync_rsp_a", 32'(bkgd_is_high_z), 32'(!RESP));
      if (k == 570) check("sync_rsp_b", 32'(bkgd_is_high_z), 32'(!RESP));
      if (k == 595) check("sync_post", 32'(bkgd_is_high_z), 1);
    end
  endtask

  initial begin
    logic [7:0] r;
    int nd;
    int n0;

    repeat (3) @(negedge clk);
    check("rst_hz", 32'(bkgd_is_high_z), 1);
    check("rst_out", 32'(bkgd_out), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_tx_busy", 32'(tx_busy), 0);
    check("rst_tx_done", 32'(tx_done), 0);
    check("rst_sync", 32'(sync_seen), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    wr_byte(8'hA5);
    repeat (3) wr_byte(8'($urandom));

    nd = n_done;
    load(8'h3C);
    @(negedge clk);
    tx_data = 8'hFF;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    rd_bits(8'h3C, 0, 7);
    check("tx_busy_mid", 32'(tx_busy), 1);
    check("tx_done_early", 32'(n_done - nd), 0);
    rd_bits(8'h3C, 7, 1);
    check("tx_done", 32'(n_done - nd), 1);
    check("tx_busy_clr", 32'(tx_busy), 0);

    r = 8'($urandom);
    nd = n_done;
    load(r);
    rd_bits(r, 0, 8);
    check("tx_done_rnd", 32'(n_done - nd), 1);

    n0 = got_q.size();
    do_sync();
    check("sync_no_rx", 32'(got_q.size() - n0), 0);

    n0 = got_q.size();
    wr_bits(8'hA5, 4);
    glitch(1);
    glitch(2);
    wr_bits(8'h50, 4);
    exp_q.push_back(8'hA5);
    check("glitch_count", 32'(got_q.size() - n0), 1);
    if (got_q.size() > 0) check("glitch_data", 32'(got_q[$]), 32'hA5);

    wr_bits(8'($urandom), 3);
    do_sync();
    wr_byte(8'h5A);

    r = 8'($urandom);
    nd = n_done;
    load(r);
    rd_bits(r, 0, 3);
    do_sync();
    check("sync_tx_busy", 32'(tx_busy), 0);
    check("sync_no_done", 32'(n_done - nd), 0);
    wr_byte(8'($urandom));

    load(8'h00);
    @(negedge clk);
    host_lvl = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      if (k == 16) host_lvl = 1'b1;
    end
    check("hold_drive", 32'(bkgd_is_high_z), 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_hz", 32'(bkgd_is_high_z), 1);
    check("rst_async_busy", 32'(tx_busy), 0);
    host_lvl = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("rx_total", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("rx_seq", 32'(got_q[i]), 32'(exp_q[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
